// File: rtl/prog_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit instruction-memory writes, core held in reset until done.
// One WRITE cycle per 4 accepted bytes; byte_ready drops outside LEN0/LEN1/DATA and the source must hold its byte.
module prog_loader #(
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = 32'hBFC00000,
  parameter int                         IMEM_WORDS    = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wd,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              words_loaded
);

  localparam int LANES      = DATA_WIDTH / 8;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ADDR_SHIFT = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         len;
  logic [15:0]         word_idx;
  logic [LANE_W-1:0]   byte_idx;
  logic [DATA_WIDTH-1:0] word;

  logic                accepting;
  logic                accept;
  logic [15:0]         len_full;
  logic                len_bad;
  logic                lane_last;
  logic                last_word;

  assign accepting = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept    = byte_valid && accepting;
  // Full length as it will be once the high byte currently on the bus is latched.
  assign len_full  = {byte_data, len[7:0]};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(IMEM_WORDS));
  assign lane_last = (byte_idx == LANE_W'(LANES - 1));
  assign last_word = (word_idx == (len - 16'd1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst    = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN0;
      end
      LEN0: begin
        byte_ready = 1'b1;
        if (accept) state_nxt = LEN1;
      end
      LEN1: begin
        byte_ready = 1'b1;
        if (accept) state_nxt = len_bad ? ERR : DATA;
      end
      DATA: begin
        byte_ready = 1'b1;
        if (accept && lane_last) state_nxt = WRITE;
      end
      WRITE: begin
        imem_we   = 1'b1;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) state_nxt = LEN0;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = LEN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len          <= 16'd0;
      word_idx     <= 16'd0;
      byte_idx     <= '0;
      word         <= '0;
      words_loaded <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            words_loaded <= 16'd0;
            word_idx     <= 16'd0;
            byte_idx     <= '0;
          end
        end
        LEN0: begin
          if (accept) len[7:0] <= byte_data;
        end
        LEN1: begin
          if (accept) begin
            len[15:8] <= byte_data;
            byte_idx  <= '0;
            word_idx  <= 16'd0;
          end
        end
        DATA: begin
          if (accept) begin
            word[8*byte_idx +: 8] <= byte_data;
            byte_idx              <= byte_idx + LANE_W'(1);
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          // Address stays on the last word once the image is complete.
          if (!last_word) word_idx <= word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = BASE_ADDR + (ADDRESS_WIDTH'(word_idx) << ADDR_SHIFT);
  assign imem_wd   = word;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads, table of header lengths with random payloads, reset and reload cases.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  always #5 CLK = ~CLK;

  prog_loader dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wd      (imem_wd),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int consec_err = 0;
  int rdy_err    = 0;
  logic prev_we  = 1'b0;

  logic [31:0] cap_a[$];
  logic [31:0] cap_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  typedef struct {
    logic [15:0] len;
    bit          exp_err;
    int          drop;
  } vec_t;

  vec_t tbl[7];

  always @(posedge CLK) cyc <= cyc + 1;

  // Write observer: records every strobe and flags back-to-back strobes or ready during a write.
  always @(negedge CLK) begin
    if (imem_we) begin
      cap_a.push_back(imem_addr);
      cap_d.push_back(imem_wd);
      if (prev_we) consec_err++;
      if (byte_ready) rdy_err++;
    end
    prev_we = imem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int drop);
    bit acc;
    int g;
    acc = 1'b0;
    g   = 0;
    while (!acc && g < 200) begin
      byte_valid = ($urandom_range(99) < drop) ? 1'b0 : 1'b1;
      byte_data  = byte_valid ? b : 8'($urandom);
      acc        = byte_valid && byte_ready;
      tick();
      g++;
    end
    byte_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_word(input logic [31:0] w, input int drop);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], drop);
  endtask

  task automatic start_pulse;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done;
    int g;
    g = 0;
    while (!done && g < 10) begin
      tick();
      g++;
    end
  endtask

  task automatic clear_all;
    cap_a.delete();
    cap_d.delete();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic check_writes(input string name);
    int bad;
    int n;
    bad = 0;
    n = (cap_a.size() < exp_a.size()) ? cap_a.size() : exp_a.size();
    check({name, "_wcount"}, 32'(cap_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < n; i++)
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) bad++;
    check({name, "_wbad"}, 32'(bad), 32'd0);
  endtask

  task automatic check_restart(input string name);
    check({name, "_rst_on_start"}, 32'(cpu_rst), 32'd1);
    check({name, "_done_clr"}, 32'(done), 32'd0);
    check({name, "_err_clr"}, 32'(err), 32'd0);
    check({name, "_wl_clr"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic load_image(input logic [15:0] len, input bit exp_err, input int drop, input string name);
    logic [31:0] w;
    clear_all();
    start_pulse();
    check_restart(name);
    send_byte(len[7:0], drop);
    send_byte(len[15:8], drop);
    if (exp_err) begin
      check({name, "_err"}, 32'(err), 32'd1);
      check({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      repeat (3) tick();
      check({name, "_err_hold"}, 32'(err), 32'd1);
      check_writes(name);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        w = $urandom;
        exp_a.push_back(BASE + 32'(i) * 32'd4);
        exp_d.push_back(w);
        push_word(w, drop);
      end
      wait_done();
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_cpu_run"}, 32'(cpu_rst), 32'd0);
      check({name, "_wl"}, 32'(words_loaded), 32'(len));
      check_writes(name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] two_word[10];
    logic [7:0] beef[6];
    int c0;

    tbl[0] = '{16'd0,     1'b1, 0};
    tbl[1] = '{16'd1025,  1'b1, 20};
    tbl[2] = '{16'd1,     1'b0, 0};
    tbl[3] = '{16'd3,     1'b0, 30};
    tbl[4] = '{16'hFFFF,  1'b1, 0};
    tbl[5] = '{16'd7,     1'b0, 50};
    tbl[6] = '{16'd1024,  1'b0, 0};

    two_word = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    beef     = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Reset with random inputs toggling
    RST = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) begin
      start      = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      tick();
    end
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wd", imem_wd, 32'd0);
    start = 1'b0; byte_valid = 1'b0;
    RST = 1'b0;
    tick();
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Two-word load, valid held high
    clear_all();
    exp_a.push_back(BASE);          exp_d.push_back(32'h00100513);
    exp_a.push_back(BASE + 32'd4);  exp_d.push_back(32'h00200593);
    start_pulse();
    c0 = cyc;
    for (int i = 0; i < 10; i++) send_byte(two_word[i], 0);
    check("tw_we_last", 32'(imem_we), 32'd1);
    check("tw_addr_last", imem_addr, 32'hBFC00004);
    check("tw_wd_last", imem_wd, 32'h00200593);
    check("tw_not_done", 32'(done), 32'd0);
    check("tw_ready_in_write", 32'(byte_ready), 32'd0);
    tick();
    check("tw_done", 32'(done), 32'd1);
    check("tw_cpu_run", 32'(cpu_rst), 32'd0);
    check("tw_wl", 32'(words_loaded), 32'd2);
    check("tw_cycles", 32'(cyc - c0), 32'd12);
    check_writes("tw");

    // Same image with random gaps, restarted from DONE
    clear_all();
    exp_a.push_back(BASE);          exp_d.push_back(32'h00100513);
    exp_a.push_back(BASE + 32'd4);  exp_d.push_back(32'h00200593);
    start_pulse();
    check_restart("bp");
    for (int i = 0; i < 10; i++) send_byte(two_word[i], 45);
    wait_done();
    check("bp_done", 32'(done), 32'd1);
    check("bp_wl", 32'(words_loaded), 32'd2);
    check_writes("bp");

    // Reload from DONE with 0xDEADBEEF
    clear_all();
    exp_a.push_back(BASE); exp_d.push_back(32'hDEADBEEF);
    start_pulse();
    check_restart("reload");
    for (int i = 0; i < 6; i++) send_byte(beef[i], 0);
    wait_done();
    check("reload_done", 32'(done), 32'd1);
    check("reload_wl", 32'(words_loaded), 32'd1);
    check_writes("reload");

    // Header length table with random payloads
    for (int i = 0; i < 7; i++)
      load_image(tbl[i].len, tbl[i].exp_err, tbl[i].drop, $sformatf("vec%0d", i));

    // Reset in the middle of word 1
    clear_all();
    start_pulse();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    RST = 1'b1;
    #1;
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_cpu", 32'(cpu_rst), 32'd1);
    check("mid_rst_wl", 32'(words_loaded), 32'd0);
    check("mid_rst_addr", imem_addr, BASE);
    repeat (3) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    RST = 1'b0;
    repeat (4) begin
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    check("mid_rst_idle_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check_writes("mid_rst");
    load_image(16'd1, 1'b0, 20, "after_rst");

    check("no_consecutive_we", 32'(consec_err), 32'd0);
    check("no_ready_during_write", 32'(rdy_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the pipelined core's instruction memory. It accepts a little-endian byte stream over a valid/ready handshake, assembles the bytes into 32-bit words, and writes them into instruction memory starting at a fixed base address. The core is held in reset until the load completes successfully. One length-prefixed image is loaded per `start`; reloading is allowed after completion or error.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction word width.
- `ADDRESS_WIDTH`, 32: instruction-memory byte-address width.
- `BASE_ADDR`, 32'hBFC00000: byte address of the first word written.
- `IMEM_WORDS`, 1024: capacity in words; maximum legal image length.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: begin a load; sampled only in IDLE, DONE and ERR.
- `byte_valid` in 1: `byte_data` holds a valid byte.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader can accept a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDRESS_WIDTH: byte address of the write; always word-aligned.
- `imem_wd` out DATA_WIDTH: word to write.
- `cpu_rst` out 1: reset to the core; high whenever no completed image is present.
- `done` out 1: image fully written.
- `err` out 1: header length was illegal.
- `words_loaded` out 16: number of words written in the current load.

## Operation
- Stream format:
  - Byte 0 is `LEN[7:0]`, byte 1 is `LEN[15:8]`.
  - LEN 32-bit words follow, each sent least-significant byte first.
- A byte is accepted on a rising edge where `byte_valid & byte_ready`. `byte_data` is don't-care when `byte_valid=0`.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
  - IDLE: `byte_ready=0`. `start` → LEN0.
  - LEN0: `byte_ready=1`. Accept → latch low length byte → LEN1.
  - LEN1: `byte_ready=1`. Accept → latch high length byte.
    - If LEN==0 or LEN>IMEM_WORDS → ERR.
    - Otherwise clear `byte_idx` and `word_idx` → DATA.
  - DATA: `byte_ready=1`. Each accept stores the byte into lane `byte_idx` (bits `8*byte_idx+7 : 8*byte_idx`), then increments `byte_idx` mod 4. Accepting lane 3 → WRITE.
  - WRITE: `byte_ready=0`, `imem_we=1`, `imem_addr = BASE_ADDR + 4*word_idx` (truncated to ADDRESS_WIDTH), `imem_wd` = assembled word.
    - `words_loaded` increments at the end of this cycle.
    - If `word_idx == LEN-1` → DONE; otherwise `word_idx++` → DATA.
  - DONE: `done=1`, `cpu_rst=0`, `byte_ready=0`. `start` → LEN0, with `cpu_rst=1`, `done=0` and `words_loaded=0` in that same cycle.
  - ERR: `err=1`, `cpu_rst=1`, `byte_ready=0`. `start` → LEN0 and clears `err`.
- `start` is ignored in LEN0, LEN1, DATA and WRITE.
- Bytes presented while `byte_ready=0` are not consumed. The stream source must hold them.
- All outputs are Moore, decoded from state and registers; no combinational input-to-output paths.
- `cpu_rst = ~(state==DONE)`.

## Timing
- Reset values (asynchronous, immediate on `RST`):
  - state IDLE.
  - `byte_ready=0`, `imem_we=0`, `imem_addr=BASE_ADDR`, `imem_wd=0`.
  - `cpu_rst=1`, `done=0`, `err=0`, `words_loaded=0`.
  - Internal length and indices 0.
- `RST` mid-load aborts immediately. A partially assembled word is never written.
- Minimum per-word cost is 5 cycles: 4 accepts plus 1 WRITE. Minimum total is 1 + 2 + 5·LEN cycles from `start` to DONE.
- `imem_we` is high for exactly one cycle per word, and never two consecutive cycles.
- `cpu_rst` falls on the first cycle after the final `imem_we` cycle.
- `done` rises in the same cycle that `cpu_rst` falls.
- `err` rises the cycle after the second header byte is accepted.
- Stalls (`byte_valid=0`) in any accepting state hold all state, with no timeout.

## Test plan
- Reset check: assert `RST` with random inputs → `cpu_rst=1`, `byte_ready=0`, `imem_we=0`, `done=0`, `err=0`, `words_loaded=0`.
- Two-word load:
  - Stimulus: `start`, then bytes 02 00 13 05 10 00 93 05 20 00 with valid held high.
  - Required: writes 0x00100513 @ 0xBFC00000 and 0x00200593 @ 0xBFC00004; exactly 2 `imem_we` pulses; `done=1`, `cpu_rst=0` the cycle after the second write; `words_loaded=2`.
- Backpressure/gaps: same image with random `byte_valid` drops → identical writes, no duplicate or missing bytes, `byte_ready` low during each WRITE.
- Illegal length:
  - Header 00 00 → `err=1`, no writes, `cpu_rst` stays 1.
  - Header 01 04 (1025) → same response.
  - Then `start` with a legal 1-word image → `err` clears and the load completes.
- Reset mid-word: assert `RST` after 2 data bytes of word 1 → no further `imem_we`, state IDLE, `cpu_rst=1`; a fresh `start` reloads from `BASE_ADDR`.
- Reload from DONE: `start` → `cpu_rst` rises that cycle, `done=0`, `words_loaded=0`; a new 1-word image 0xDEADBEEF lands at 0xBFC00000.
